dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 90 +++++++++
 tb/tb_dm_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Four-core data-memory arbiter: one outstanding access at a time, round-robin grant.
// Define DM_ARB_FIXED_PRIO_EN for fixed priority (core0 highest) instead of round-robin.
module dm_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int WDATA_W = 16,
  parameter int RDATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [3:0]           we,
  input  logic [4*ADDR_W-1:0]  addr,
  input  logic [4*WDATA_W-1:0] wdata,
  output logic [3:0]           gnt,
  output logic [3:0]           rvalid,
  output logic [RDATA_W-1:0]   rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WDATA_W-1:0]   mem_wdata,
  input  logic [RDATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [1:0] p;
  logic [1:0] win;
  logic [1:0] idx;
  logic [1:0] lat_w;
  logic       lat_we;

  // Search p, p+1, p+2, p+3 (mod 4); with the fixed-priority build p stays 0.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (req[idx]) win = idx;
    end
  end

  // mem_addr/mem_wdata double as the latched request: loaded only on grant,
  // so they hold their last value outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      p         <= '0;
      lat_w     <= '0;
      lat_we    <= 1'b0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          lat_w     <= win;
          lat_we    <= we[win];
          gnt       <= 4'b0001 << win;
          mem_en    <= 1'b1;
          mem_we    <= we[win];
          mem_addr  <= addr[win*ADDR_W +: ADDR_W];
          mem_wdata <= wdata[win*WDATA_W +: WDATA_W];
`ifdef DM_ARB_FIXED_PRIO_EN
          p         <= '0;
`else
          p         <= win + 2'd1;
`endif
          state     <= ISSUE;
        end
        ISSUE: state <= lat_we ? IDLE : WAIT;
        WAIT: begin
          rdata  <= mem_rdata;
          rvalid <= 4'b0001 << lat_w;
          state  <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: write, read, arbitration order, reset abort, dropped request.
module tb_dm_arbiter;
  localparam int ADDR_W = 8, WDATA_W = 16, RDATA_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [3:0]           req, we;
  logic [4*ADDR_W-1:0]  addr;
  logic [4*WDATA_W-1:0] wdata;
  logic [3:0]           gnt, rvalid;
  logic [RDATA_W-1:0]   rdata;
  logic                 mem_en, mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [WDATA_W-1:0]   mem_wdata;
  logic [RDATA_W-1:0]   mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  dm_arbiter #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory returns addr ^ 8'h7E one cycle after a read strobe.
  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= mem_addr ^ 8'h7E;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (rst_n === 1'b1) begin
    chk("gnt_rvalid_exclusive", {31'd0, ($onehot0(gnt) && $onehot0(rvalid) && !(|gnt && |rvalid))}, 32'd1);
  end

  initial begin
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick();

    // write from core 0
    req = 4'b0001; we = 4'b0001; addr[7:0] = 8'h10; wdata[15:0] = 16'h00AB;
    tick();
    chk("wr_gnt", gnt, 4'b0001);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 8'h10);
    chk("wr_mem_wdata", mem_wdata, 16'h00AB);
    chk("wr_rvalid", rvalid, 0);
    req = '0;
    tick();
    chk("wr_idle_gnt", gnt, 0);
    chk("wr_idle_mem_en", mem_en, 0);
    chk("wr_idle_mem_we", mem_we, 0);
    chk("wr_hold_addr", mem_addr, 8'h10);
    tick();
    chk("wr_no_rvalid", rvalid, 0);

    // read from core 2
    req = 4'b0100; we = 4'b0000; addr[23:16] = 8'h22;
    tick();
    chk("rd_gnt", gnt, 4'b0100);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 8'h22);
    req = '0;
    tick();
    chk("rd_wait_gnt", gnt, 0);
    chk("rd_wait_rvalid", rvalid, 0);
    chk("rd_wait_mem_en", mem_en, 0);
    tick();
    chk("rd_rvalid", rvalid, 4'b0100);
    chk("rd_rdata", rdata, 8'h5C);
    tick();
    chk("rd_rvalid_clr", rvalid, 0);
    chk("rd_rdata_hold", rdata, 8'h5C);

    // reset restores p=0 before the ordering test
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

`ifndef DM_ARB_FIXED_PRIO_EN
    req = 4'b1111; we = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_gnt%0d", i), gnt, 32'(4'b0001 << i));
      req[i] = 1'b0;
      tick();
    end
    // last grant was core 3: wrap back to core 0
    req = 4'b1001;
    tick();
    chk("wrap_gnt0", gnt, 4'b0001);
    tick();
    // p now 1, so core 3 wins over a re-requesting core 0
    tick();
    chk("rr_after0_gnt3", gnt, 4'b1000);
    req = '0;
    tick();
`else
    req = 4'b1010; we = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fp_gnt1_%0d", i), gnt, 4'b0010);
      tick();
    end
    req = 4'b1001;
    tick();
    chk("fp_gnt0", gnt, 4'b0001);
    tick();
    tick();
    chk("fp_gnt0_again", gnt, 4'b0001);
    req = '0;
    tick();
`endif

    // reset during WAIT aborts the read
    req = 4'b0001; we = 4'b0000; addr[7:0] = 8'h40;
    tick();
    chk("rst_rd_gnt", gnt, 4'b0001);
    req = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_rvalid", rvalid, 0);
    chk("rstmid_mem_en", mem_en, 0);
    chk("rstmid_rdata", rdata, 0);
    chk("rstmid_mem_addr", mem_addr, 0);
    tick();
    chk("rstmid_rvalid2", rvalid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_rvalid", rvalid, 0);
    chk("post_rst_gnt", gnt, 0);
    // p=0 after reset: core 0 beats core 3
    req = 4'b1001; we = 4'b1001;
    tick();
    chk("post_rst_first_gnt", gnt, 4'b0001);
    req = '0;
    tick();

    // request withdrawn before the sampling edge
    @(negedge clk);
    req = 4'b0010;
    #2;
    req = '0;
    tick();
    chk("drop_gnt", gnt, 0);
    chk("drop_mem_en", mem_en, 0);
    tick();
    chk("drop_gnt2", gnt, 0);
    chk("drop_mem_en2", mem_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
